// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: APB3 slave front-end that turns each APB transfer into
// exactly one UART core command strobe, waits for the core (or a timeout)
// and completes the APB access with captured read data and error status.
module uart_apb_sequencer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int CORE_ADDR_WIDTH = 2,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [ADDR_WIDTH-1:0]      PADDR,
    input  logic [DATA_WIDTH-1:0]      PWDATA,
    output logic [DATA_WIDTH-1:0]      PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    output logic [DATA_WIDTH-1:0]      write_data_in,
    output logic [CORE_ADDR_WIDTH-1:0] config_address,
    output logic                       config_write_detect,
    output logic                       config_read_detect,
    output logic                       TX_detect,
    output logic                       RX_detect,
    input  logic [DATA_WIDTH-1:0]      core_read_data,
    input  logic                       core_ready,
    input  logic                       core_error,
    output logic                       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // One-hot command encoding; bit order matches the strobe outputs.
    localparam logic [3:0] CMD_NONE   = 4'b0000;
    localparam logic [3:0] CMD_CFG_WR = 4'b0001;
    localparam logic [3:0] CMD_CFG_RD = 4'b0010;
    localparam logic [3:0] CMD_TX     = 4'b0100;
    localparam logic [3:0] CMD_RX     = 4'b1000;

    // Last counter value of the WAIT window before the access is aborted.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    // Map the low address bits and direction onto a command; CMD_NONE means
    // the access is illegal (unmapped, misaligned or wrong direction).
    function automatic logic [3:0] decode_cmd(input logic [4:0] addr, input logic wr);
        logic [3:0] cmd;
        cmd = CMD_NONE;
        case (addr)
            5'h00, 5'h04, 5'h08, 5'h0C: cmd = wr ? CMD_CFG_WR : CMD_CFG_RD;
            5'h10:                      cmd = wr ? CMD_TX : CMD_NONE;
            5'h14:                      cmd = wr ? CMD_NONE : CMD_RX;
            default:                    cmd = CMD_NONE;
        endcase
        return cmd;
    endfunction

    state_e                     state_q, state_d;
    logic [3:0]                 strobe_q, strobe_d;
    logic [CORE_ADDR_WIDTH-1:0] cfg_addr_q, cfg_addr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]      prdata_q, prdata_d;
    logic                       pready_q, pready_d;
    logic                       pslverr_q, pslverr_d;
    logic                       busy_q, busy_d;
    logic                       pwrite_q, pwrite_d;
    logic [15:0]                count_q, count_d;
    logic [3:0]                 cmd_s;

    // Only PADDR[4:0] selects a register; the upper bits are ignored.
    logic unused_paddr_s;
    assign unused_paddr_s = ^PADDR;

    // Decode of the current setup phase, consumed only in IDLE.
    assign cmd_s = decode_cmd(PADDR[4:0], PWRITE);

    // Next-state and next-output logic for the sequencing FSM.
    always_comb begin
        state_d    = state_q;
        strobe_d   = strobe_q;
        cfg_addr_d = cfg_addr_q;
        wdata_d    = wdata_q;
        pwrite_d   = pwrite_q;
        count_d    = count_q;
        prdata_d   = {DATA_WIDTH{1'b0}};
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    pwrite_d = PWRITE;
                    if (cmd_s != CMD_NONE) begin
                        state_d  = ST_ISSUE;
                        strobe_d = cmd_s;
                        if ((cmd_s == CMD_CFG_WR) || (cmd_s == CMD_CFG_RD)) begin
                            cfg_addr_d = CORE_ADDR_WIDTH'(PADDR[3:2]);
                        end else begin
                            cfg_addr_d = cfg_addr_q;
                        end
                        if (PWRITE) begin
                            wdata_d = PWDATA;
                        end else begin
                            wdata_d = wdata_q;
                        end
                    end else begin
                        // Illegal access completes at once with an error.
                        state_d   = ST_DONE;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!PSEL) begin
                    state_d  = ST_IDLE;
                    strobe_d = CMD_NONE;
                end else begin
                    state_d = ST_WAIT;
                    count_d = 16'd0;
                end
            end
            ST_WAIT: begin
                count_d = count_q + 16'd1;
                if (!PSEL) begin
                    // Master abandoned the transfer: no completion pulse.
                    state_d  = ST_IDLE;
                    strobe_d = CMD_NONE;
                end else if (core_ready) begin
                    state_d   = ST_DONE;
                    strobe_d  = CMD_NONE;
                    pready_d  = 1'b1;
                    pslverr_d = core_error;
                    if (pwrite_q) begin
                        prdata_d = {DATA_WIDTH{1'b0}};
                    end else begin
                        prdata_d = core_read_data;
                    end
                end else if (count_q == TIMEOUT_LAST) begin
                    state_d   = ST_DONE;
                    strobe_d  = CMD_NONE;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                strobe_d = CMD_NONE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs, cleared immediately by PRESET.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= ST_IDLE;
            strobe_q   <= CMD_NONE;
            cfg_addr_q <= {CORE_ADDR_WIDTH{1'b0}};
            wdata_q    <= {DATA_WIDTH{1'b0}};
            prdata_q   <= {DATA_WIDTH{1'b0}};
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            busy_q     <= 1'b0;
            pwrite_q   <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            strobe_q   <= strobe_d;
            cfg_addr_q <= cfg_addr_d;
            wdata_q    <= wdata_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            busy_q     <= busy_d;
            pwrite_q   <= pwrite_d;
            count_q    <= count_d;
        end
    end

    assign config_write_detect = strobe_q[0];
    assign config_read_detect  = strobe_q[1];
    assign TX_detect           = strobe_q[2];
    assign RX_detect           = strobe_q[3];
    assign config_address      = cfg_addr_q;
    assign write_data_in       = wdata_q;
    assign PRDATA              = prdata_q;
    assign PREADY              = pready_q;
    assign PSLVERR             = pslverr_q;
    assign busy                = busy_q;

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Directed self-checking bench for uart_apb_sequencer. Instance dut uses a
// 16-cycle timeout; instance dut_l keeps the default timeout for long waits.
module tb_uart_apb_sequencer;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] core_read_data;
    logic        core_ready, core_error;

    logic [31:0] prdata, wdi;
    logic        pready, pslverr, busy;
    logic [1:0]  caddr;
    logic        cfg_wr, cfg_rd, tx, rx;

    logic [31:0] l_prdata, l_wdi;
    logic        l_pready, l_pslverr, l_busy;
    logic [1:0]  l_caddr;
    logic        l_cfg_wr, l_cfg_rd, l_tx, l_rx;

    logic [3:0] strb, l_strb;
    assign strb   = {rx, tx, cfg_rd, cfg_wr};
    assign l_strb = {l_rx, l_tx, l_cfg_rd, l_cfg_wr};

    int n_vec = 0;
    int n_err = 0;

    always #5 PCLK = ~PCLK;

    uart_apb_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata),
        .PREADY(pready), .PSLVERR(pslverr), .write_data_in(wdi),
        .config_address(caddr), .config_write_detect(cfg_wr),
        .config_read_detect(cfg_rd), .TX_detect(tx), .RX_detect(rx),
        .core_read_data(core_read_data), .core_ready(core_ready),
        .core_error(core_error), .busy(busy)
    );

    uart_apb_sequencer dut_l (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(l_prdata),
        .PREADY(l_pready), .PSLVERR(l_pslverr), .write_data_in(l_wdi),
        .config_address(l_caddr), .config_write_detect(l_cfg_wr),
        .config_read_detect(l_cfg_rd), .TX_detect(l_tx), .RX_detect(l_rx),
        .core_read_data(core_read_data), .core_ready(core_ready),
        .core_error(core_error), .busy(l_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic setup(input logic [31:0] addr, input logic wr, input logic [31:0] data);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = data;
    endtask

    task automatic bus_idle();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Transfer where the core answers one cycle after the strobe rises.
    task automatic fast_xfer(input string tag, input logic [31:0] addr, input logic wr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic cerr, input logic [3:0] exp_strb,
                             input logic [1:0] exp_caddr, input logic [31:0] exp_prdata,
                             input logic exp_err);
        tick(); setup(addr, wr, wdata);
        @(negedge PCLK);
        check_eq({tag, "_t0_strb"}, 32'(strb), 32'h0);
        tick(); PENABLE = 1'b1;
        @(negedge PCLK);
        check_eq({tag, "_t1_strb"}, 32'(strb), 32'(exp_strb));
        check_eq({tag, "_t1_caddr"}, 32'(caddr), 32'(exp_caddr));
        check_eq({tag, "_t1_busy"}, 32'(busy), 32'h1);
        check_eq({tag, "_t1_pready"}, 32'(pready), 32'h0);
        if (wr) check_eq({tag, "_t1_wdata"}, wdi, wdata);
        tick(); core_ready = 1'b1; core_read_data = rdata; core_error = cerr;
        @(negedge PCLK);
        check_eq({tag, "_t2_strb"}, 32'(strb), 32'(exp_strb));
        check_eq({tag, "_t2_pready"}, 32'(pready), 32'h0);
        tick(); core_ready = 1'b0; core_error = 1'b0;
        @(negedge PCLK);
        check_eq({tag, "_t3_pready"}, 32'(pready), 32'h1);
        check_eq({tag, "_t3_pslverr"}, 32'(pslverr), 32'(exp_err));
        check_eq({tag, "_t3_prdata"}, prdata, exp_prdata);
        check_eq({tag, "_t3_strb"}, 32'(strb), 32'h0);
        tick(); bus_idle();
        @(negedge PCLK);
        check_eq({tag, "_t4_pready"}, 32'(pready), 32'h0);
        check_eq({tag, "_t4_prdata"}, prdata, 32'h0);
        check_eq({tag, "_t4_busy"}, 32'(busy), 32'h0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
    } ill_t;

    initial begin
        int hi;
        int rdy;
        int bsy;
        ill_t ill [5];
        ill[0] = '{32'h0000_0010, 1'b0};
        ill[1] = '{32'h0000_0018, 1'b1};
        ill[2] = '{32'h0000_0014, 1'b1};
        ill[3] = '{32'h0000_0002, 1'b1};
        ill[4] = '{32'h0000_001C, 1'b0};

        PRESET = 1'b1; bus_idle(); PWRITE = 1'b0; PADDR = 32'h0; PWDATA = 32'h0;
        core_read_data = 32'h0; core_ready = 1'b0; core_error = 1'b0;
        repeat (2) @(negedge PCLK);
        check_eq("rst_strb", 32'(strb), 32'h0);
        check_eq("rst_pready", 32'(pready), 32'h0);
        check_eq("rst_pslverr", 32'(pslverr), 32'h0);
        check_eq("rst_prdata", prdata, 32'h0);
        check_eq("rst_wdi", wdi, 32'h0);
        check_eq("rst_caddr", 32'(caddr), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        tick(); PRESET = 1'b0;

        // Config write: core read data must not leak into PRDATA on a write.
        fast_xfer("cfgwr0", 32'h0000_0000, 1'b1, 32'h0000_2580, 32'hFFFF_FFFF, 1'b0,
                  4'b0001, 2'd0, 32'h0, 1'b0);
        check_eq("cfgwr0_hold_wdi", wdi, 32'h0000_2580);
        // Config read with upper address bits set (ignored by decode).
        fast_xfer("cfgrd4", 32'h4000_0004, 1'b0, 32'h0, 32'h0000_0008, 1'b0,
                  4'b0010, 2'd1, 32'h0000_0008, 1'b0);
        // Config write where the core flags an error.
        fast_xfer("cfgwr8err", 32'h0000_0008, 1'b1, 32'h0000_0001, 32'h0, 1'b1,
                  4'b0001, 2'd2, 32'h0, 1'b1);

        // TX write with a 200-cycle core delay; core_ready is pulsed in IDLE
        // and ISSUE first and must be ignored there.
        tick(); setup(32'h0000_0010, 1'b1, 32'h0000_00A5); core_ready = 1'b1;
        core_read_data = 32'h0000_1234;
        @(negedge PCLK);
        hi = 0; rdy = 0; bsy = 0;
        for (int i = 1; i <= 200; i++) begin
            tick(); PENABLE = 1'b1; core_ready = (i == 1);
            @(negedge PCLK);
            if (l_strb == 4'b0100) hi++;
            if (l_pready) rdy++;
            if (l_busy) bsy++;
        end
        check_eq("tx_strobe_cycles", 32'(hi), 32'd200);
        check_eq("tx_early_pready", 32'(rdy), 32'd0);
        check_eq("tx_busy_cycles", 32'(bsy), 32'd200);
        check_eq("tx_wdi", l_wdi, 32'h0000_00A5);
        tick(); core_ready = 1'b1;
        @(negedge PCLK);
        check_eq("tx_t201_strb", 32'(l_strb), 32'h4);
        tick(); core_ready = 1'b0;
        @(negedge PCLK);
        check_eq("tx_done_pready", 32'(l_pready), 32'h1);
        check_eq("tx_done_pslverr", 32'(l_pslverr), 32'h0);
        check_eq("tx_done_prdata", l_prdata, 32'h0);
        check_eq("tx_done_strb", 32'(l_strb), 32'h0);
        tick(); bus_idle();
        @(negedge PCLK);
        check_eq("tx_after_pready", 32'(l_pready), 32'h0);
        check_eq("tx_after_busy", 32'(l_busy), 32'h0);

        // RX read with no core response: timeout after 16 WAIT cycles.
        tick(); setup(32'h0000_0014, 1'b0, 32'h0); core_read_data = 32'hDEAD_BEEF;
        @(negedge PCLK);
        hi = 0; rdy = 0;
        for (int i = 0; i < 17; i++) begin
            tick(); PENABLE = 1'b1;
            @(negedge PCLK);
            if (strb == 4'b1000) hi++;
            if (pready) rdy++;
        end
        check_eq("rx_strobe_cycles", 32'(hi), 32'd17);
        check_eq("rx_early_pready", 32'(rdy), 32'd0);
        tick();
        @(negedge PCLK);
        check_eq("rx_to_pready", 32'(pready), 32'h1);
        check_eq("rx_to_pslverr", 32'(pslverr), 32'h1);
        check_eq("rx_to_prdata", prdata, 32'h0);
        check_eq("rx_to_strb", 32'(strb), 32'h0);
        tick(); bus_idle();
        @(negedge PCLK);
        check_eq("rx_after_pready", 32'(pready), 32'h0);

        // Illegal accesses back to back: zero wait states, error, no strobe.
        for (int k = 0; k < 5; k++) begin
            tick(); setup(ill[k].addr, ill[k].wr, 32'h0000_00FF);
            @(negedge PCLK);
            check_eq($sformatf("ill%0d_t0_pready", k), 32'(pready), 32'h0);
            tick(); PENABLE = 1'b1;
            @(negedge PCLK);
            check_eq($sformatf("ill%0d_pready", k), 32'(pready), 32'h1);
            check_eq($sformatf("ill%0d_pslverr", k), 32'(pslverr), 32'h1);
            check_eq($sformatf("ill%0d_strb", k), 32'(strb), 32'h0);
            check_eq($sformatf("ill%0d_prdata", k), prdata, 32'h0);
        end
        tick(); bus_idle();
        @(negedge PCLK);
        check_eq("ill_after_pready", 32'(pready), 32'h0);
        check_eq("ill_after_busy", 32'(busy), 32'h0);

        // Protocol violation: PSEL dropped during WAIT.
        tick(); setup(32'h0000_000C, 1'b1, 32'h0000_0002);
        @(negedge PCLK);
        tick(); PENABLE = 1'b1;
        @(negedge PCLK);
        tick(); bus_idle();
        @(negedge PCLK);
        check_eq("abort_wait_strb", 32'(strb), 32'h1);
        tick();
        @(negedge PCLK);
        check_eq("abort_strb", 32'(strb), 32'h0);
        check_eq("abort_busy", 32'(busy), 32'h0);
        check_eq("abort_pready", 32'(pready), 32'h0);
        tick();
        @(negedge PCLK);
        check_eq("abort_pready2", 32'(pready), 32'h0);

        // Reset asserted during WAIT of a TX write takes effect immediately.
        tick(); setup(32'h0000_0010, 1'b1, 32'h0000_005A);
        @(negedge PCLK);
        tick(); PENABLE = 1'b1;
        tick();
        tick();
        @(negedge PCLK);
        check_eq("rstw_pre_strb", 32'(l_strb), 32'h4);
        PRESET = 1'b1;
        #1;
        check_eq("rstw_strb", 32'(l_strb), 32'h0);
        check_eq("rstw_busy", 32'(l_busy), 32'h0);
        check_eq("rstw_pready", 32'(l_pready), 32'h0);
        check_eq("rstw_wdi", l_wdi, 32'h0);
        check_eq("rstw_main_strb", 32'(strb), 32'h0);
        tick(); PRESET = 1'b0; bus_idle();
        fast_xfer("cfgrdC", 32'h0000_000C, 1'b0, 32'h0, 32'h0000_0003, 1'b0,
                  4'b0010, 2'd3, 32'h0000_0003, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
